mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter: AW, 5, address width (32-word memory).
REQ-002 Parameter: DW, 8, data width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 f_req  in  1  instruction-fetch read request; held high until f_done.
REQ-006 f_addr  in  AW  fetch address; stable while f_req high.
REQ-007 f_done  out  1  one-cycle pulse: fetch complete, f_rdata valid.
REQ-008 f_rdata  out  DW  fetched word; held until next fetch completes.
REQ-009 d_req  in  1  data request (LDA read / STO write); held high until d_done.
REQ-010 d_we  in  1  1 = write, 0 = read; stable while d_req high.
REQ-011 d_addr  in  AW  data address; stable while d_req high.
REQ-012 d_wdata  in  DW  store data; stable while d_req high.
REQ-013 d_done  out  1  one-cycle pulse: data access complete.
REQ-014 d_rdata  out  DW  loaded word; held until next data read completes.
REQ-015 halt  in  1  from controller stop; blocks new grants.
REQ-016 mem_sel  out  1  memory select, high only in ACCESS.
REQ-017 mem_we  out  1  memory write strobe, high only in ACCESS of a write.
REQ-018 mem_addr  out  AW  latched winner address.
REQ-019 mem_wdata  out  DW  latched winner store data.
REQ-020 mem_rdata  in  DW  memory read data, valid at end of ACCESS cycle.
REQ-021 busy  out  1  high whenever state is not IDLE.

Function
REQ-022 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on grant, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-023 In IDLE with halt=0 and any req high: pick winner, latch owner, addr, we, wdata at that edge; halt=1 or no req: stay IDLE.
REQ-024 mem_sel, mem_we, mem_addr, mem_wdata registered outputs; mem_we forced 0 for fetch owner.
REQ-025 In RESP: read -> owner rdata <= mem_rdata captured at ACCESS->RESP edge; owner done high for exactly the RESP cycle.
REQ-026 Write: d_done pulses in RESP; d_rdata, f_rdata unchanged.
REQ-027 Latency: req sampled at edge k -> mem_sel high cycle k+1 -> done high cycle k+2; one transaction per 3 cycles max.
REQ-028 req high in an IDLE cycle is a new request; requester drops req the cycle after done if no further access.
REQ-029 Both req at same IDLE edge: winner per REQ-035/036; loser keeps req, served in following transaction.
REQ-030 halt rising during ACCESS/RESP: in-flight transaction completes normally; no further grant until halt=0.
REQ-031 Non-owner done never asserted; f_done and d_done never high together.
REQ-032 Addresses used verbatim, no increment, no wrap; AW-bit width preserved end to end.

Reset
REQ-033 rst_n low: state IDLE, busy/mem_sel/mem_we/f_done/d_done = 0, mem_addr/mem_wdata/f_rdata/d_rdata = 0, last_gnt = data, immediately and asynchronously.
REQ-034 Reset mid-ACCESS/RESP: transaction aborted, no done pulse; requester reissues after rst_n high.

Configuration
REQ-035 MEM_ARB_RR_EN defined: on tie, grant port not granted last; last_gnt updates on every grant; first tie after reset goes to fetch.
REQ-036 MEM_ARB_RR_EN undefined: fixed priority, data always beats fetch; last_gnt logic absent.

Verification
REQ-037 Fetch only, f_addr=5'h03, mem[3]=8'hA5 -> mem_sel high cycle k+1, f_done pulse k+2, f_rdata=8'hA5.
REQ-038 Store d_we=1, d_addr=5'h1F, d_wdata=8'h3C -> mem_we=1 one cycle, mem_addr=5'h1F, d_done pulse, readback 8'h3C.
REQ-039 f_req and d_req same edge, both held: RR_EN -> fetch, data, fetch alternation; without -> data served every 3 cycles, fetch starved.
REQ-040 halt=1 asserted during ACCESS of a load -> d_done still pulses, busy 0 after, no mem_sel while halt=1.
REQ-041 rst_n low during ACCESS -> mem_sel 0 same cycle, no done, state IDLE, outputs at reset values.

Source files
------------

// File: rtl/mem_arb.sv
// mem_arb: arbiter between an instruction-fetch port and a data port that share one
// single-ported 32-word memory. Each granted transaction takes three cycles:
// IDLE (grant) -> ACCESS (mem_sel high) -> RESP (owner done pulse).
//
// Optional feature macro: MEM_ARB_RR_EN
//   defined   - round-robin on simultaneous requests (first tie after reset goes to fetch)
//   undefined - fixed priority, data always beats fetch
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   f_req, f_addr                       fetch request / address
//   f_done, f_rdata                     fetch completion pulse / fetched word
//   d_req, d_we, d_addr, d_wdata        data request / write enable / address / store data
//   d_done, d_rdata                     data completion pulse / loaded word
//   halt                                blocks new grants while high
//   mem_sel, mem_we, mem_addr,
//   mem_wdata, mem_rdata                memory-side interface
//   busy                                high whenever a transaction is in flight
module mem_arb #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_done,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    input  logic          halt,
    output logic          mem_sel,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]    state_q;
    logic          owner_data_q;  // 1 = data port owns the in-flight transaction
    logic          mem_sel_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] f_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          f_done_q;
    logic          d_done_q;

    logic          gnt_any;
    logic          gnt_data;

`ifdef MEM_ARB_RR_EN
    logic          last_gnt_data_q;  // 1 = data was granted most recently

    // On a tie the port that did not win last time is served.
    assign gnt_data = d_req && (!f_req || !last_gnt_data_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_data_q <= 1'b1;
        end else if (gnt_any) begin
            last_gnt_data_q <= gnt_data;
        end
    end
`else
    assign gnt_data = d_req;
`endif

    assign gnt_any = (state_q == IDLE) && !halt && (f_req || d_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_data_q <= 1'b0;
            mem_sel_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            f_rdata_q    <= '0;
            d_rdata_q    <= '0;
            f_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        state_q      <= ACCESS;
                        owner_data_q <= gnt_data;
                        mem_sel_q    <= 1'b1;
                        mem_we_q     <= gnt_data && d_we;
                        mem_addr_q   <= gnt_data ? d_addr : f_addr;
                        // Fetches never write, so keep the previous store data.
                        if (gnt_data) begin
                            mem_wdata_q <= d_wdata;
                        end
                    end
                end
                ACCESS: begin
                    state_q   <= RESP;
                    mem_sel_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    if (owner_data_q) begin
                        d_done_q <= 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_q <= mem_rdata;
                        end
                    end else begin
                        f_done_q  <= 1'b1;
                        f_rdata_q <= mem_rdata;
                    end
                end
                RESP: begin
                    state_q  <= IDLE;
                    f_done_q <= 1'b0;
                    d_done_q <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_sel_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    f_done_q  <= 1'b0;
                    d_done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign mem_sel   = mem_sel_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign f_rdata   = f_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign f_done    = f_done_q;
    assign d_done    = d_done_q;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: self-checking bench for mem_arb. A behavioural memory sits on the memory
// port; a transaction-level reference (winner choice, expected read data, held rdata)
// predicts every cycle of each grant.
module tb_mem_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       f_req, d_req, d_we, halt;
    logic [4:0] f_addr, d_addr;
    logic [7:0] d_wdata;
    logic       f_done, d_done, mem_sel, mem_we, busy;
    logic [7:0] f_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [4:0] mem_addr;

    // Memory model with a preload path so only one process writes the array.
    logic [7:0] mem [32];
    logic       pl_en;
    logic [4:0] pl_a;
    logic [7:0] pl_d;

    logic [7:0] ref_mem [32];
    logic [7:0] exp_frd, exp_drd;
    bit         ref_last_data;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (mem_sel && mem_we) mem[mem_addr] <= mem_wdata;
    end

    mem_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_done    (f_done),
        .f_rdata   (f_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .halt      (halt),
        .mem_sel   (mem_sel),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Winner choice from the arbitration rule: 1 = data port wins.
    function automatic bit pick(input bit fr, input bit dr);
`ifdef MEM_ARB_RR_EN
        if (fr && dr) return !ref_last_data;
        return dr;
`else
        return dr;
`endif
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sel"}, mem_sel, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_fdone"}, f_done, 0);
        chk({tag, "_ddone"}, d_done, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_frd"}, f_rdata, 0);
        chk({tag, "_drd"}, d_rdata, 0);
    endtask

    // Called in an IDLE cycle with requests driven; runs one full transaction and ends
    // #1 after the edge that returns the arbiter to IDLE.
    task automatic run_grant(input bit keep, input bit hlt);
        bit         w;
        bit         we;
        logic [4:0] a;
        w  = pick(f_req, d_req);
        ref_last_data = w;
        a  = w ? d_addr : f_addr;
        we = w && d_we;
        @(posedge clk); #1;
        chk("acc_sel", mem_sel, 1);
        chk("acc_we", mem_we, we);
        chk("acc_addr", mem_addr, a);
        if (we) chk("acc_wdata", mem_wdata, d_wdata);
        chk("acc_busy", busy, 1);
        chk("acc_fdone", f_done, 0);
        chk("acc_ddone", d_done, 0);
        if (hlt) halt = 1'b1;
        if (we) ref_mem[a] = d_wdata;
        else if (w) exp_drd = ref_mem[a];
        else exp_frd = ref_mem[a];
        @(posedge clk); #1;
        chk("rsp_fdone", f_done, !w);
        chk("rsp_ddone", d_done, w);
        chk("rsp_sel", mem_sel, 0);
        chk("rsp_we", mem_we, 0);
        chk("rsp_frd", f_rdata, exp_frd);
        chk("rsp_drd", d_rdata, exp_drd);
        chk("rsp_busy", busy, 1);
        if (!keep) begin
            if (w) d_req = 1'b0;
            else f_req = 1'b0;
        end
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_fdone", f_done, 0);
        chk("idle_ddone", d_done, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        f_req = 0; d_req = 0; d_we = 0; halt = 0;
        f_addr = '0; d_addr = '0; d_wdata = '0;
        pl_en = 0; pl_a = '0; pl_d = '0;
        exp_frd = '0; exp_drd = '0;
        ref_last_data = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // Preload memory while still in reset.
        for (int i = 0; i < 32; i++) begin
            pl_en = 1'b1;
            pl_a  = 5'(i);
            pl_d  = (i == 3) ? 8'hA5 : 8'($urandom);
            ref_mem[i] = pl_d;
            @(posedge clk); #1;
        end
        pl_en = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Plain fetch of a known word.
        f_req = 1'b1; f_addr = 5'h03;
        run_grant(0, 0);
        chk("fetch_a5", f_rdata, 8'hA5);

        // Store to the top address, then load it back.
        d_req = 1'b1; d_we = 1'b1; d_addr = 5'h1F; d_wdata = 8'h3C;
        run_grant(0, 0);
        d_req = 1'b1; d_we = 1'b0;
        run_grant(0, 0);
        chk("readback_3c", d_rdata, 8'h3C);

        // Both ports held through four grants.
        f_req = 1'b1; f_addr = 5'h07;
        d_req = 1'b1; d_we = 1'b0; d_addr = 5'h11;
        repeat (4) run_grant(1, 0);
        f_req = 1'b0; d_req = 1'b0;

        // halt raised during ACCESS of a load.
        d_req = 1'b1; d_we = 1'b0; d_addr = 5'h09;
        run_grant(0, 1);
        f_req = 1'b1; f_addr = 5'h04;
        repeat (4) begin
            @(posedge clk); #1;
            chk("halt_sel", mem_sel, 0);
            chk("halt_busy", busy, 0);
        end
        halt = 1'b0;
        run_grant(0, 0);

        // Reset in the middle of ACCESS aborts the fetch.
        f_req = 1'b1; f_addr = 5'h12;
        @(posedge clk); #1;
        chk("pre_rst_sel", mem_sel, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        f_req = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_fdone", f_done, 0);
            chk("rst_ddone", d_done, 0);
        end
        exp_frd = '0; exp_drd = '0; ref_last_data = 1'b1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        f_req = 1'b1;
        run_grant(0, 0);

        // Random traffic.
        for (int it = 0; it < 40; it++) begin
            f_req   = 1'($urandom);
            d_req   = 1'($urandom);
            if (!f_req && !d_req) d_req = 1'b1;
            f_addr  = 5'($urandom);
            d_addr  = 5'($urandom);
            d_we    = 1'($urandom);
            d_wdata = 8'($urandom);
            while (f_req || d_req) run_grant(0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
